multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control FSM that sequences the shared-ALU, single-memory multicycle version of the RV32I datapath.
//  Decodes op/funct fields, drives every mux select and write enable each cycle, and stalls on a memory ready handshake.
//  Sits beside the datapath; its outputs connect directly to PC, IR, register file, ALU and memory-address muxes.
//  Supported instructions: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal.
// PARAMETERS
//  none (opcode and ALU encodings below are fixed)
// PORTS
//  CLK         in   1  rising-edge clock
//  RESET       in   1  asynchronous, active-low reset
//  EN          in   1  1 = run; 0 = hold state, all write enables forced 0
//  op          in   7  Instr[6:0] from IR
//  funct3      in   3  Instr[14:12]
//  funct7b5    in   1  Instr[30]
//  Zero        in   1  ALU zero flag
//  MemReady    in   1  memory completes access this cycle
//  PCWrite     out  1  PC load enable
//  AdrSrc      out  1  memory address: 0 = PC, 1 = Result
//  MemWrite    out  1  data memory write enable
//  IRWrite     out  1  IR/OldPC load enable
//  ResultSrc   out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
//  ALUSrcA     out  2  00 = PC, 01 = OldPC, 10 = A(rs1)
//  ALUSrcB     out  2  00 = B(rs2), 01 = ImmExt, 10 = const 4
//  ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  ImmSrc      out  2  00 I, 01 S, 10 B, 11 J (combinational from op)
//  RegWrite    out  1  register file write enable
//  Illegal     out  1  sticky: unsupported opcode decoded
//  State       out  4  current state code (debug)
// BEHAVIOUR
//  - States and codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
//  - Reset (RESET=0): State=FETCH immediately, Illegal=0, and all write enables (PCWrite, IRWrite, MemWrite, RegWrite) are 0 while RESET is low.
//  - Outputs are combinational from State (plus MemReady/Zero where noted). Unlisted selects are 00; unlisted enables are 0.
//  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10; IRWrite=PCWrite=MemReady.
//      Transition: go to DECODE if MemReady, else stay in FETCH.
//  - DECODE: ALUSrcA=01, ALUSrcB=01, add (computes branch target into ALUOut).
//      op 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; any other -> TRAP.
//  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. Transition: op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
//  - MEMREAD: AdrSrc=1, ResultSrc=00. Go to MEMWB on MemReady, else hold.
//  - MEMWB: ResultSrc=01, RegWrite=1. Then -> FETCH.
//  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 every cycle held. Go to FETCH on MemReady, else hold.
//  - EXECR: ALUSrcA=10, ALUSrcB=00, funct decode. EXECI: ALUSrcA=10, ALUSrcB=01, funct decode. Both then -> ALUWB.
//  - ALUWB: ResultSrc=00, RegWrite=1. Then -> FETCH.
//  - BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero. Then -> FETCH.
//  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Then -> ALUWB (rd <- OldPC+4).
//  - Funct decode: funct3 000 -> sub if {op[5],funct7b5}=11, else add; 010 -> slt; 110 -> or; 111 -> and; other funct3 -> add.
//  - TRAP: all enables 0, Illegal=1. Stays in TRAP until reset.
//  - EN=0: State frozen; PCWrite/IRWrite/MemWrite/RegWrite forced 0; selects still driven from State.
//  - Cycle counts with MemReady=1 throughout: lw 5, sw 4, R/I 4, beq 3, jal 4.
// TESTING
//  1. lw (op=0000011), MemReady=1: States 0,1,2,3,4,0. RegWrite=1 with ResultSrc=01 only in state 4; IRWrite=1 only in state 0.
//  2. R-type sub (op=0110011, f3=000, f7b5=1): ALUControl=001 in EXECR. With f7b5=0: 000. addi with f7b5=1: 000.
//  3. beq, Zero=1: PCWrite=1 in BEQ (state 9). With Zero=0: PCWrite=0 and the FSM returns to FETCH.
//  4. MemReady=0 for 3 cycles in FETCH: State stays 0 and IRWrite=PCWrite=0 for those cycles. On the 4th cycle (MemReady=1) both pulse, then DECODE.
//  5. op=0000000 decoded: State goes to 11, Illegal=1, and both hold for 20 cycles. Deassert then reassert RESET: State=0, Illegal=0.
//  6. sw stalled in MEMWRITE (MemWrite=1), RESET pulled low mid-cycle: MemWrite drops to 0 asynchronously and State=0.
//     EN=0 during ALUWB: RegWrite=0 and State holds at 8.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle RV32I controller and its datapath.
// The master side is the controller; the slave side is the datapath.
interface multicycle_controller_if;
  logic       EN;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  EN, op, funct3, funct7b5, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, Illegal, State
  );

  modport slave (
    output EN, op, funct3, funct7b5, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, Illegal, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for the shared-ALU, single-memory multicycle RV32I datapath.
// Mux selects and write enables are decoded from the current state each cycle.
module multicycle_controller (
  input  logic                   CLK,
  input  logic                   RESET,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state_q;
  logic       illegal_q;
  logic       pc_write, ir_write, mem_write, reg_write;
  logic       adr_src;
  logic [1:0] result_src, src_a, src_b, imm_src;
  logic [2:0] alu_ctl;

  function automatic logic [2:0] funct_alu(input logic [2:0] f3, input logic op5,
                                           input logic f7b5);
    logic [2:0] ctl;
    case (f3)
      3'b000:  ctl = (op5 && f7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  ctl = ALU_SLT;
      3'b110:  ctl = ALU_OR;
      3'b111:  ctl = ALU_AND;
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  // NOTE: state uses non-blocking assignments and an asynchronous reset so
  // every register samples its pre-edge value and clears without a clock.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else if (bus.EN) begin
      case (state_q)
        S_FETCH:    if (bus.MemReady) state_q <= S_DECODE;
        S_DECODE: begin
          case (bus.op)
            7'b0000011, 7'b0100011: state_q <= S_MEMADR;
            7'b0110011:             state_q <= S_EXECR;
            7'b0010011:             state_q <= S_EXECI;
            7'b1100011:             state_q <= S_BEQ;
            7'b1101111:             state_q <= S_JAL;
            default: begin
              state_q   <= S_TRAP;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_MEMADR:   state_q <= bus.op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (bus.MemReady) state_q <= S_MEMWB;
        S_MEMWRITE: if (bus.MemReady) state_q <= S_FETCH;
        S_EXECR, S_EXECI, S_JAL:      state_q <= S_ALUWB;
        S_MEMWB, S_ALUWB, S_BEQ:      state_q <= S_FETCH;
        S_TRAP:     state_q <= S_TRAP;
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    src_a      = 2'b00;
    src_b      = 2'b00;
    alu_ctl    = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        src_b      = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.MemReady;
        pc_write   = bus.MemReady;
      end
      S_DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
      end
      S_MEMADR: begin
        src_a = 2'b10;
        src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        src_a   = 2'b10;
        alu_ctl = funct_alu(bus.funct3, bus.op[5], bus.funct7b5);
      end
      S_EXECI: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu_ctl = funct_alu(bus.funct3, bus.op[5], bus.funct7b5);
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ: begin
        src_a    = 2'b10;
        alu_ctl  = ALU_SUB;
        pc_write = bus.Zero;
      end
      S_JAL: begin
        src_a    = 2'b01;
        src_b    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (bus.op)
      7'b0100011: imm_src = 2'b01;
      7'b1100011: imm_src = 2'b10;
      7'b1101111: imm_src = 2'b11;
      default:    imm_src = 2'b00;
    endcase
  end

  // Enables are also gated by RESET so they stay low for the whole reset pulse.
  assign bus.PCWrite    = pc_write  & bus.EN & RESET;
  assign bus.IRWrite    = ir_write  & bus.EN & RESET;
  assign bus.MemWrite   = mem_write & bus.EN & RESET;
  assign bus.RegWrite   = reg_write & bus.EN & RESET;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ALUControl = alu_ctl;
  assign bus.ImmSrc     = imm_src;
  assign bus.Illegal    = illegal_q;
  assign bus.State      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the driver queues hand-computed
// per-cycle expectations, the monitor pops and compares them on the falling edge.
module tb_multicycle_controller;

  logic CLK = 1'b0;
  logic RESET;
  multicycle_controller_if bus ();

  multicycle_controller dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  always #5 CLK = ~CLK;

  typedef struct {
    int         id;
    logic [3:0] st;
    logic [3:0] we;   // {PCWrite, IRWrite, MemWrite, RegWrite}
    logic [6:0] sel;  // {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB}
    logic [2:0] alu;
    logic [1:0] imm;
    logic       ill;
  } exp_t;

  localparam logic [6:0] SEL_F  = 7'b0_10_00_10;
  localparam logic [6:0] SEL_D  = 7'b0_00_01_01;
  localparam logic [6:0] SEL_MA = 7'b0_00_10_01;
  localparam logic [6:0] SEL_MR = 7'b1_00_00_00;
  localparam logic [6:0] SEL_MB = 7'b0_01_00_00;
  localparam logic [6:0] SEL_MW = 7'b1_00_00_00;
  localparam logic [6:0] SEL_ER = 7'b0_00_10_00;
  localparam logic [6:0] SEL_EI = 7'b0_00_10_01;
  localparam logic [6:0] SEL_WB = 7'b0_00_00_00;
  localparam logic [6:0] SEL_BQ = 7'b0_00_10_00;
  localparam logic [6:0] SEL_J  = 7'b0_00_01_10;
  localparam logic [6:0] SEL_T  = 7'b0_00_00_00;

  exp_t       sb_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         vec_n  = 0;
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;
  logic [1:0] cur_imm;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [1:0] imm);
    cur_op  = op;
    cur_f3  = f3;
    cur_f7  = f7;
    cur_imm = imm;
  endtask

  // One clock cycle: apply inputs just after the edge and queue what the DUT must show.
  task automatic cyc(input logic rst, input logic en, input logic zero, input logic mr,
                     input logic [3:0] st, input logic [3:0] we, input logic [6:0] sel,
                     input logic [2:0] alu, input logic ill);
    exp_t e;
    @(posedge CLK);
    #1;
    RESET        = rst;
    bus.EN       = en;
    bus.Zero     = zero;
    bus.MemReady = mr;
    bus.op       = cur_op;
    bus.funct3   = cur_f3;
    bus.funct7b5 = cur_f7;
    e.id  = vec_n;
    e.st  = st;
    e.we  = we;
    e.sel = sel;
    e.alu = alu;
    e.imm = cur_imm;
    e.ill = ill;
    vec_n++;
    sb_q.push_back(e);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("v%0d.State", e.id), 8'(bus.State), 8'(e.st));
      check($sformatf("v%0d.we", e.id),
            8'({bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}), 8'(e.we));
      check($sformatf("v%0d.sel", e.id),
            8'({bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB}), 8'(e.sel));
      check($sformatf("v%0d.ALUControl", e.id), 8'(bus.ALUControl), 8'(e.alu));
      check($sformatf("v%0d.ImmSrc", e.id), 8'(bus.ImmSrc), 8'(e.imm));
      check($sformatf("v%0d.Illegal", e.id), 8'(bus.Illegal), 8'(e.ill));
    end
  end

  initial begin
    RESET = 1'b0;
    set_instr(7'b0000011, 3'b010, 1'b0, 2'b00);
    bus.EN = 1'b1; bus.Zero = 1'b0; bus.MemReady = 1'b1;
    bus.op = cur_op; bus.funct3 = cur_f3; bus.funct7b5 = cur_f7;
    #2;
    check("reset.State", 8'(bus.State), 8'd0);
    check("reset.Illegal", 8'(bus.Illegal), 8'd0);
    check("reset.IRWrite", 8'(bus.IRWrite), 8'd0);
    cyc(0, 1, 0, 1, 4'd0, 4'b0000, SEL_F, 3'b000, 0);

    // lw with MemReady high: 0,1,2,3,4 then FETCH
    cyc(1, 1, 0, 1, 4'd0, 4'b1100, SEL_F,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd1, 4'b0000, SEL_D,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd2, 4'b0000, SEL_MA, 3'b000, 0);
    cyc(1, 1, 0, 1, 4'd3, 4'b0000, SEL_MR, 3'b000, 0);
    cyc(1, 1, 0, 1, 4'd4, 4'b0001, SEL_MB, 3'b000, 0);

    // R-type / I-type funct decode
    set_instr(7'b0110011, 3'b000, 1'b1, 2'b00);           // sub
    cyc(1, 1, 0, 1, 4'd0, 4'b1100, SEL_F,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd1, 4'b0000, SEL_D,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd6, 4'b0000, SEL_ER, 3'b001, 0);
    cyc(1, 1, 0, 1, 4'd8, 4'b0001, SEL_WB, 3'b000, 0);
    set_instr(7'b0110011, 3'b000, 1'b0, 2'b00);           // add
    cyc(1, 1, 0, 1, 4'd0, 4'b1100, SEL_F,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd1, 4'b0000, SEL_D,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd6, 4'b0000, SEL_ER, 3'b000, 0);
    cyc(1, 1, 0, 1, 4'd8, 4'b0001, SEL_WB, 3'b000, 0);
    set_instr(7'b0010011, 3'b000, 1'b1, 2'b00);           // addi, f7b5 set
    cyc(1, 1, 0, 1, 4'd0, 4'b1100, SEL_F,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd1, 4'b0000, SEL_D,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd7, 4'b0000, SEL_EI, 3'b000, 0);
    cyc(1, 1, 0, 1, 4'd8, 4'b0001, SEL_WB, 3'b000, 0);
    set_instr(7'b0110011, 3'b010, 1'b0, 2'b00);           // slt
    cyc(1, 1, 0, 1, 4'd0, 4'b1100, SEL_F,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd1, 4'b0000, SEL_D,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd6, 4'b0000, SEL_ER, 3'b101, 0);
    cyc(1, 1, 0, 1, 4'd8, 4'b0001, SEL_WB, 3'b000, 0);
    set_instr(7'b0010011, 3'b111, 1'b0, 2'b00);           // andi
    cyc(1, 1, 0, 1, 4'd0, 4'b1100, SEL_F,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd1, 4'b0000, SEL_D,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd7, 4'b0000, SEL_EI, 3'b010, 0);
    cyc(1, 1, 0, 1, 4'd8, 4'b0001, SEL_WB, 3'b000, 0);
    set_instr(7'b0110011, 3'b110, 1'b0, 2'b00);           // or
    cyc(1, 1, 0, 1, 4'd0, 4'b1100, SEL_F,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd1, 4'b0000, SEL_D,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd6, 4'b0000, SEL_ER, 3'b011, 0);
    cyc(1, 1, 0, 1, 4'd8, 4'b0001, SEL_WB, 3'b000, 0);

    // beq taken then not taken
    set_instr(7'b1100011, 3'b000, 1'b0, 2'b10);
    cyc(1, 1, 0, 1, 4'd0, 4'b1100, SEL_F,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd1, 4'b0000, SEL_D,  3'b000, 0);
    cyc(1, 1, 1, 1, 4'd9, 4'b1000, SEL_BQ, 3'b001, 0);
    cyc(1, 1, 0, 1, 4'd0, 4'b1100, SEL_F,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd1, 4'b0000, SEL_D,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd9, 4'b0000, SEL_BQ, 3'b001, 0);

    // sw with a three-cycle fetch stall
    set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
    cyc(1, 1, 0, 0, 4'd0, 4'b0000, SEL_F,  3'b000, 0);
    cyc(1, 1, 0, 0, 4'd0, 4'b0000, SEL_F,  3'b000, 0);
    cyc(1, 1, 0, 0, 4'd0, 4'b0000, SEL_F,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd0, 4'b1100, SEL_F,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd1, 4'b0000, SEL_D,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd2, 4'b0000, SEL_MA, 3'b000, 0);
    cyc(1, 1, 0, 1, 4'd5, 4'b0010, SEL_MW, 3'b000, 0);

    // lw stalled in MEMREAD
    set_instr(7'b0000011, 3'b010, 1'b0, 2'b00);
    cyc(1, 1, 0, 1, 4'd0, 4'b1100, SEL_F,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd1, 4'b0000, SEL_D,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd2, 4'b0000, SEL_MA, 3'b000, 0);
    cyc(1, 1, 0, 0, 4'd3, 4'b0000, SEL_MR, 3'b000, 0);
    cyc(1, 1, 0, 0, 4'd3, 4'b0000, SEL_MR, 3'b000, 0);
    cyc(1, 1, 0, 1, 4'd3, 4'b0000, SEL_MR, 3'b000, 0);
    cyc(1, 1, 0, 1, 4'd4, 4'b0001, SEL_MB, 3'b000, 0);

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0, 2'b11);
    cyc(1, 1, 0, 1, 4'd0,  4'b1100, SEL_F,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd1,  4'b0000, SEL_D,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd10, 4'b1000, SEL_J,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd8,  4'b0001, SEL_WB, 3'b000, 0);

    // EN low during ALUWB, then during FETCH
    set_instr(7'b0010011, 3'b000, 1'b0, 2'b00);
    cyc(1, 1, 0, 1, 4'd0, 4'b1100, SEL_F,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd1, 4'b0000, SEL_D,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd7, 4'b0000, SEL_EI, 3'b000, 0);
    cyc(1, 0, 0, 1, 4'd8, 4'b0000, SEL_WB, 3'b000, 0);
    cyc(1, 0, 0, 1, 4'd8, 4'b0000, SEL_WB, 3'b000, 0);
    cyc(1, 1, 0, 1, 4'd8, 4'b0001, SEL_WB, 3'b000, 0);
    set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
    cyc(1, 0, 0, 1, 4'd0, 4'b0000, SEL_F,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd0, 4'b1100, SEL_F,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd1, 4'b0000, SEL_D,  3'b000, 0);
    cyc(1, 1, 0, 1, 4'd2, 4'b0000, SEL_MA, 3'b000, 0);
    cyc(1, 1, 0, 0, 4'd5, 4'b0010, SEL_MW, 3'b000, 0);
    cyc(1, 1, 0, 0, 4'd5, 4'b0010, SEL_MW, 3'b000, 0);

    // reset asserted mid-cycle while sw is stalled in MEMWRITE
    @(negedge CLK);
    #2;
    check("mw_before_rst.MemWrite", 8'(bus.MemWrite), 8'd1);
    RESET = 1'b0;
    #1;
    check("mw_async_rst.MemWrite", 8'(bus.MemWrite), 8'd0);
    check("mw_async_rst.State", 8'(bus.State), 8'd0);
    cyc(0, 1, 0, 1, 4'd0, 4'b0000, SEL_F, 3'b000, 0);

    // illegal opcode: TRAP is sticky for 20 cycles, cleared only by reset
    set_instr(7'b0000000, 3'b000, 1'b0, 2'b00);
    cyc(1, 1, 0, 1, 4'd0, 4'b1100, SEL_F, 3'b000, 0);
    cyc(1, 1, 0, 1, 4'd1, 4'b0000, SEL_D, 3'b000, 0);
    for (int i = 0; i < 20; i++)
      cyc(1, 1, 0, 1, 4'd11, 4'b0000, SEL_T, 3'b000, 1);
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    check("trap_rst.State", 8'(bus.State), 8'd0);
    check("trap_rst.Illegal", 8'(bus.Illegal), 8'd0);
    cyc(0, 1, 0, 1, 4'd0, 4'b0000, SEL_F, 3'b000, 0);
    cyc(1, 1, 0, 1, 4'd0, 4'b1100, SEL_F, 3'b000, 0);

    repeat (2) @(posedge CLK);
    check("scoreboard_drained", 8'(sb_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
